// File: rtl/midi_alloc_pkg.sv
// Shared definitions for the MIDI voice allocator.
// Holds the command nibbles and controller numbers the allocator reacts to,
// the FSM state and candidate-category encodings, and the event decoder
// used at the accept edge.
package midi_alloc_pkg;

    // MIDI status nibbles (upper half of the status byte, channel ignored)
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] CC       = 4'hB;

    // Controller numbers that silence every voice
    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'h78;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

    // Allocator FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_RETRIG = 2'd2;
    localparam logic [1:0] ST_LOAD   = 2'd3;

    // Candidate categories, higher value wins during the scan
    localparam logic [1:0] CAT_NONE  = 2'd0;
    localparam logic [1:0] CAT_STEAL = 2'd1;
    localparam logic [1:0] CAT_FREE  = 2'd2;
    localparam logic [1:0] CAT_REUSE = 2'd3;

    typedef enum logic [1:0] {
        EVT_OTHER    = 2'd0,
        EVT_NOTE_ON  = 2'd1,
        EVT_NOTE_OFF = 2'd2,
        EVT_ALL_OFF  = 2'd3
    } evt_kind_e;

    // Classify an incoming event; a note-on with zero velocity is a note-off.
    function automatic evt_kind_e decode_evt(input logic [3:0] nib,
                                             input logic [6:0] p1,
                                             input logic [6:0] p2);
        evt_kind_e kind;
        kind = EVT_OTHER;
        case (nib)
            NOTE_ON:  kind = (p2 != 7'd0) ? EVT_NOTE_ON : EVT_NOTE_OFF;
            NOTE_OFF: kind = EVT_NOTE_OFF;
            CC:       kind = ((p1 == CC_ALL_SOUND_OFF) || (p1 == CC_ALL_NOTES_OFF))
                             ? EVT_ALL_OFF : EVT_OTHER;
            default:  kind = EVT_OTHER;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Event handshake between the MIDI framer (master) and the voice allocator
// (slave).
//   evt_valid : framer has an event        evt_ready : allocator can take it
//   evt_cmd   : status byte                evt_p1    : note / CC number
//   evt_p2    : velocity / CC value
interface midi_voice_allocator_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_cmd;
    logic [6:0] evt_p1;
    logic [6:0] evt_p2;

    modport master (
        output evt_valid,
        output evt_cmd,
        output evt_p1,
        output evt_p2,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_cmd,
        input  evt_p1,
        input  evt_p2,
        output evt_ready
    );
endinterface

// File: rtl/midi_voice_picker.sv
// Sequential best-candidate tracker for note-on voice selection.
// Fed one voice per cycle while en is high; clr restarts the search.
//   clk, rst_n       : clock, async active-low reset
//   clr              : forget the running best (start of a scan)
//   en               : a candidate is presented this cycle
//   cand_*           : gate / note / age / index of the presented voice
//   target_note      : note being allocated
//   res_idx/res_gate : best voice so far, including the current candidate
// Ranking: same-note reuse (first index wins) beats a free voice, which beats
// a sounding voice; within free/sounding the oldest wins, ties to lower index.
module midi_voice_picker
    import midi_alloc_pkg::*;
#(
    parameter int IDX_W    = 2,
    parameter int AGE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                cand_gate,
    input  logic [6:0]          cand_note,
    input  logic [AGE_BITS-1:0] cand_age,
    input  logic [IDX_W-1:0]    cand_idx,
    input  logic [6:0]          target_note,
    output logic [IDX_W-1:0]    res_idx,
    output logic                res_gate
);

    localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};

    logic [1:0]          best_cat_r;
    logic [AGE_BITS-1:0] best_age_r;
    logic [IDX_W-1:0]    best_idx_r;
    logic                best_gate_r;

    logic [1:0]          cand_cat_s;
    logic                take_s;
    logic [1:0]          res_cat_s;
    logic [AGE_BITS-1:0] res_age_s;

    // Categorise the candidate and merge it with the running best.
    always_comb begin
        cand_cat_s = CAT_STEAL;
        take_s     = 1'b0;
        // A saturated age marks a voice never assigned since reset, so its
        // note register is meaningless for reuse.
        if ((cand_note == target_note) && (cand_age != AGE_MAX)) begin
            cand_cat_s = CAT_REUSE;
        end else if (!cand_gate) begin
            cand_cat_s = CAT_FREE;
        end else begin
            cand_cat_s = CAT_STEAL;
        end

        // Strict comparisons keep the earlier (lower) index on ties.
        if (en) begin
            if (cand_cat_s > best_cat_r) begin
                take_s = 1'b1;
            end else if ((cand_cat_s == best_cat_r) && (cand_cat_s != CAT_REUSE)
                         && (cand_age > best_age_r)) begin
                take_s = 1'b1;
            end else begin
                take_s = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end

        if (take_s) begin
            res_cat_s = cand_cat_s;
            res_age_s = cand_age;
            res_idx   = cand_idx;
            res_gate  = cand_gate;
        end else begin
            res_cat_s = best_cat_r;
            res_age_s = best_age_r;
            res_idx   = best_idx_r;
            res_gate  = best_gate_r;
        end
    end

    // Running best register, restarted at each scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_cat_r  <= CAT_NONE;
            best_age_r  <= {AGE_BITS{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            best_gate_r <= 1'b0;
        end else if (clr) begin
            best_cat_r  <= CAT_NONE;
            best_age_r  <= {AGE_BITS{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            best_gate_r <= 1'b0;
        end else if (en) begin
            best_cat_r  <= res_cat_s;
            best_age_r  <= res_age_s;
            best_idx_r  <= res_idx;
            best_gate_r <= res_gate;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator between the MIDI framer and the voice bank.
//   clk, rst_n      : clock, async active-low reset
//   evt             : event handshake (slave side)
//   voice_gate      : per-voice gate
//   voice_note      : per-voice note, voice i at [7i+6:7i]
//   voice_load      : one-cycle strobe when a voice is assigned
//   voice_load_idx  : assigned voice index
//   voice_load_vel  : velocity of the assigned note
// Note-ons scan every voice (one per cycle), then either load directly or,
// when the chosen voice is sounding, hold its gate low for RETRIG_CYCLES so
// the envelope sees a fresh rising edge. Note-offs use the same scan to clear
// matching gates. All-notes/sound-off clears every gate on acceptance.
module midi_voice_allocator
    import midi_alloc_pkg::*;
#(
    parameter  int NUM_VOICES    = 4,
    parameter  int RETRIG_CYCLES = 512,
    parameter  int AGE_BITS      = 8,
    localparam int IDX_W         = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    midi_voice_allocator_if.slave   evt,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic                    voice_load,
    output logic [IDX_W-1:0]        voice_load_idx,
    output logic [6:0]              voice_load_vel
);

    localparam logic [AGE_BITS-1:0] AGE_MAX   = {AGE_BITS{1'b1}};
    localparam int                  CNT_W     = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RETRIG_CYCLES - 1);
    localparam logic [IDX_W-1:0]    SCAN_LAST = IDX_W'(NUM_VOICES - 1);

    logic [1:0]          state_r;
    logic [IDX_W-1:0]    scan_idx_r;
    logic [CNT_W-1:0]    retrig_cnt_r;
    logic                is_off_r;
    logic [6:0]          p1_r;
    logic [6:0]          p2_r;
    logic [IDX_W-1:0]    sel_idx_r;

    logic [NUM_VOICES-1:0] gate_r;
    logic [6:0]            note_r [NUM_VOICES];
    logic [AGE_BITS-1:0]   age_r  [NUM_VOICES];
    logic                  load_r;
    logic [IDX_W-1:0]      load_idx_r;
    logic [6:0]            load_vel_r;

    logic                  accept_s;
    logic                  scan_last_s;
    evt_kind_e             kind_s;
    logic                  pick_en_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_gate_s;
    logic [3:0]            unused_chan_s;

    assign evt.evt_ready = (state_r == ST_IDLE);
    assign accept_s      = evt.evt_valid && (state_r == ST_IDLE);
    assign kind_s        = decode_evt(evt.evt_cmd[7:4], evt.evt_p1, evt.evt_p2);
    assign unused_chan_s = evt.evt_cmd[3:0];
    assign scan_last_s   = (scan_idx_r == SCAN_LAST);
    assign pick_en_s     = (state_r == ST_SCAN) && !is_off_r;

    assign voice_gate     = gate_r;
    assign voice_load     = load_r;
    assign voice_load_idx = load_idx_r;
    assign voice_load_vel = load_vel_r;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_pack
        assign voice_note[7*g +: 7] = note_r[g];
    end

    midi_voice_picker #(
        .IDX_W    (IDX_W),
        .AGE_BITS (AGE_BITS)
    ) u_picker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept_s),
        .en          (pick_en_s),
        .cand_gate   (gate_r[scan_idx_r]),
        .cand_note   (note_r[scan_idx_r]),
        .cand_age    (age_r[scan_idx_r]),
        .cand_idx    (scan_idx_r),
        .target_note (p1_r),
        .res_idx     (pick_idx_s),
        .res_gate    (pick_gate_s)
    );

    // Control FSM: accept, scan, optional retrigger gap, load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            scan_idx_r   <= {IDX_W{1'b0}};
            retrig_cnt_r <= {CNT_W{1'b0}};
            is_off_r     <= 1'b0;
            p1_r         <= 7'd0;
            p2_r         <= 7'd0;
            sel_idx_r    <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        p1_r         <= evt.evt_p1;
                        p2_r         <= evt.evt_p2;
                        scan_idx_r   <= {IDX_W{1'b0}};
                        retrig_cnt_r <= {CNT_W{1'b0}};
                        case (kind_s)
                            EVT_NOTE_ON: begin
                                is_off_r <= 1'b0;
                                state_r  <= ST_SCAN;
                            end
                            EVT_NOTE_OFF: begin
                                is_off_r <= 1'b1;
                                state_r  <= ST_SCAN;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_SCAN: begin
                    scan_idx_r <= scan_idx_r + IDX_W'(1);
                    if (scan_last_s) begin
                        if (is_off_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            // The picker's merged result already includes the last voice.
                            sel_idx_r <= pick_idx_s;
                            state_r   <= pick_gate_s ? ST_RETRIG : ST_LOAD;
                        end
                    end
                end
                ST_RETRIG: begin
                    if (retrig_cnt_r == CNT_LAST) begin
                        state_r <= ST_LOAD;
                    end else begin
                        retrig_cnt_r <= retrig_cnt_r + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Voice state and load strobe; ages move only when a voice is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_r     <= {NUM_VOICES{1'b0}};
            load_r     <= 1'b0;
            load_idx_r <= {IDX_W{1'b0}};
            load_vel_r <= 7'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 7'd0;
                age_r[i]  <= AGE_MAX;
            end
        end else begin
            load_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (kind_s == EVT_ALL_OFF)) begin
                        gate_r <= {NUM_VOICES{1'b0}};
                    end
                end
                ST_SCAN: begin
                    // The note register is kept so a later same-note on can reuse it.
                    if (is_off_r && gate_r[scan_idx_r] && (note_r[scan_idx_r] == p1_r)) begin
                        gate_r[scan_idx_r] <= 1'b0;
                    end
                end
                ST_RETRIG: begin
                    gate_r[sel_idx_r] <= 1'b0;
                end
                ST_LOAD: begin
                    gate_r[sel_idx_r] <= 1'b1;
                    note_r[sel_idx_r] <= p1_r;
                    load_r            <= 1'b1;
                    load_idx_r        <= sel_idx_r;
                    load_vel_r        <= p2_r;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == sel_idx_r) begin
                            age_r[i] <= {AGE_BITS{1'b0}};
                        end else if (age_r[i] != AGE_MAX) begin
                            age_r[i] <= age_r[i] + AGE_BITS'(1);
                        end
                    end
                end
                default: begin
                    gate_r <= gate_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with 4 voices and an 8-cycle
// retrigger gap. A table of events with hand-computed results drives the
// main function; short hand-written sequences cover stealing, same-note
// retrigger and reset during the retrigger gap.
module tb_midi_voice_allocator;

    localparam int NV = 4;
    localparam int RC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    midi_voice_allocator_if evt_if ();

    logic [NV-1:0]   voice_gate;
    logic [7*NV-1:0] voice_note;
    logic            voice_load;
    logic [1:0]      voice_load_idx;
    logic [6:0]      voice_load_vel;

    midi_voice_allocator #(
        .NUM_VOICES    (NV),
        .RETRIG_CYCLES (RC),
        .AGE_BITS      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evt            (evt_if),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_load     (voice_load),
        .voice_load_idx (voice_load_idx),
        .voice_load_vel (voice_load_vel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent send()
    int         r_busy;
    int         r_loads;
    int         r_load_e;
    int         r_fall_e;
    int         r_rise_e;
    logic [1:0] r_idx;
    logic [6:0] r_vel;

    typedef struct {
        logic [7:0] cmd;
        logic [6:0] p1;
        logic [6:0] p2;
        logic [3:0] gate;
        int         busy;
        logic       load;
        logic [1:0] idx;
        logic [6:0] vel;
        int         nidx;
        logic [6:0] note;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    // Offer one event, then follow the DUT until it is ready again.
    // Sample e is taken 1 time unit after the e-th edge following the accept
    // edge (e=0 is right after the accept edge itself).
    task automatic send(input logic [7:0] cmd, input logic [6:0] p1, input logic [6:0] p2,
                        input int trk, input int limit);
        int   w;
        logic prev;
        w = 0;
        while (evt_if.evt_ready !== 1'b1 && w < limit) begin
            @(posedge clk); #1;
            w++;
        end
        if (evt_if.evt_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_wait: evt_ready still %b after %0d cycles", evt_if.evt_ready, w);
        end
        prev = voice_gate[trk];
        evt_if.evt_valid = 1'b1;
        evt_if.evt_cmd   = cmd;
        evt_if.evt_p1    = p1;
        evt_if.evt_p2    = p2;
        @(posedge clk); #1;
        evt_if.evt_valid = 1'b0;
        evt_if.evt_cmd   = 8'h00;
        evt_if.evt_p1    = 7'd0;
        evt_if.evt_p2    = 7'd0;
        r_busy = -1; r_loads = 0; r_load_e = -1; r_fall_e = -1; r_rise_e = -1;
        r_idx = 2'd0; r_vel = 7'd0;
        for (int e = 0; e <= limit; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (voice_load === 1'b1) begin
                r_loads++;
                r_load_e = e;
                r_idx    = voice_load_idx;
                r_vel    = voice_load_vel;
            end
            if (prev === 1'b1 && voice_gate[trk] === 1'b0 && r_fall_e < 0) r_fall_e = e;
            if (prev === 1'b0 && voice_gate[trk] === 1'b1 && r_rise_e < 0) r_rise_e = e;
            prev = voice_gate[trk];
            if (evt_if.evt_ready === 1'b1) begin
                r_busy = e;
                break;
            end
        end
        if (r_busy < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: evt_ready not back within %0d cycles", limit);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_four();
        send(8'h90, 7'd60, 7'd100, 0, 100);
        send(8'h90, 7'd62, 7'd90,  0, 100);
        send(8'h90, 7'd64, 7'd80,  0, 100);
        send(8'h90, 7'd65, 7'd70,  0, 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads_in_reset;

        evt_if.evt_valid = 1'b0;
        evt_if.evt_cmd   = 8'h00;
        evt_if.evt_p1    = 7'd0;
        evt_if.evt_p2    = 7'd0;

        //            cmd    p1     p2      gate    busy load idx  vel     nidx note
        vecs[0]  = '{8'h90, 7'd60, 7'd100, 4'b0001, 5, 1'b1, 2'd0, 7'd100, 0, 7'd60};
        vecs[1]  = '{8'h90, 7'd62, 7'd90,  4'b0011, 5, 1'b1, 2'd1, 7'd90,  1, 7'd62};
        vecs[2]  = '{8'h90, 7'd64, 7'd80,  4'b0111, 5, 1'b1, 2'd2, 7'd80,  2, 7'd64};
        vecs[3]  = '{8'h90, 7'd65, 7'd70,  4'b1111, 5, 1'b1, 2'd3, 7'd70,  3, 7'd65};
        vecs[4]  = '{8'h80, 7'd62, 7'd64,  4'b1101, 4, 1'b0, 2'd0, 7'd0,   1, 7'd62};
        vecs[5]  = '{8'h90, 7'd67, 7'd50,  4'b1111, 5, 1'b1, 2'd1, 7'd50,  1, 7'd67};
        vecs[6]  = '{8'h90, 7'd64, 7'd0,   4'b1011, 4, 1'b0, 2'd0, 7'd0,   2, 7'd64};
        vecs[7]  = '{8'h91, 7'd64, 7'd77,  4'b1111, 5, 1'b1, 2'd2, 7'd77,  2, 7'd64};
        vecs[8]  = '{8'hB0, 7'h7B, 7'd0,   4'b0000, 0, 1'b0, 2'd0, 7'd0,  -1, 7'd0};
        vecs[9]  = '{8'hB0, 7'h07, 7'd100, 4'b0000, 0, 1'b0, 2'd0, 7'd0,  -1, 7'd0};
        vecs[10] = '{8'hC0, 7'd5,  7'd0,   4'b0000, 0, 1'b0, 2'd0, 7'd0,  -1, 7'd0};
        vecs[11] = '{8'h90, 7'd65, 7'd33,  4'b1000, 5, 1'b1, 2'd3, 7'd33,  3, 7'd65};
        vecs[12] = '{8'hB3, 7'h78, 7'd0,   4'b0000, 0, 1'b0, 2'd0, 7'd0,  -1, 7'd0};
        vecs[13] = '{8'h85, 7'd0,  7'd0,   4'b0000, 4, 1'b0, 2'd0, 7'd0,  -1, 7'd0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_gate",  32'(voice_gate), 32'd0);
        check("rst_note",  32'(voice_note), 32'd0);
        check("rst_load",  32'(voice_load), 32'd0);
        check("rst_idx",   32'(voice_load_idx), 32'd0);
        check("rst_vel",   32'(voice_load_vel), 32'd0);
        check("rst_ready", 32'(evt_if.evt_ready), 32'd1);
        rst_n = 1'b1;

        // Table-driven main function
        for (int v = 0; v < 14; v++) begin
            send(vecs[v].cmd, vecs[v].p1, vecs[v].p2, 0, 100);
            check($sformatf("vec%0d_gate", v),  32'(voice_gate), 32'(vecs[v].gate));
            check($sformatf("vec%0d_busy", v),  32'(r_busy), 32'(vecs[v].busy));
            check($sformatf("vec%0d_loads", v), 32'(r_loads), 32'(vecs[v].load));
            if (vecs[v].load) begin
                check($sformatf("vec%0d_load_idx", v), 32'(r_idx), 32'(vecs[v].idx));
                check($sformatf("vec%0d_load_vel", v), 32'(r_vel), 32'(vecs[v].vel));
            end
            if (vecs[v].nidx >= 0) begin
                check($sformatf("vec%0d_note", v), 32'(note_of(vecs[v].nidx)), 32'(vecs[v].note));
            end
        end

        // Steal: fifth note with every voice sounding takes the oldest (voice 0)
        do_reset();
        fill_four();
        send(8'h90, 7'd67, 7'd20, 0, 100);
        check("steal_fall_e", 32'(r_fall_e), 32'd5);
        check("steal_rise_e", 32'(r_rise_e), 32'd13);
        check("steal_load_e", 32'(r_load_e), 32'd13);
        check("steal_busy",   32'(r_busy), 32'd13);
        check("steal_idx",    32'(r_idx), 32'd0);
        check("steal_vel",    32'(r_vel), 32'd20);
        check("steal_note0",  32'(note_of(0)), 32'd67);
        check("steal_gate",   32'(voice_gate), 32'hF);

        // Same-note reuse: released voice without gap, sounding voice with gap
        do_reset();
        send(8'h90, 7'd60, 7'd1, 0, 100);
        send(8'h80, 7'd60, 7'd0, 0, 100);
        check("reuse_off_gate", 32'(voice_gate), 32'd0);
        send(8'h90, 7'd60, 7'd2, 0, 100);
        check("reuse_idx",    32'(r_idx), 32'd0);
        check("reuse_fall_e", r_fall_e, -1);
        check("reuse_rise_e", 32'(r_rise_e), 32'd5);
        send(8'h90, 7'd60, 7'd9, 0, 100);
        check("retrig_fall_e", 32'(r_fall_e), 32'd5);
        check("retrig_rise_e", 32'(r_rise_e), 32'd13);
        check("retrig_idx",    32'(r_idx), 32'd0);
        check("retrig_vel",    32'(r_vel), 32'd9);
        check("retrig_gate",   32'(voice_gate), 32'd1);

        // Reset in the middle of the retrigger gap
        do_reset();
        fill_four();
        evt_if.evt_valid = 1'b1;
        evt_if.evt_cmd   = 8'h90;
        evt_if.evt_p1    = 7'd67;
        evt_if.evt_p2    = 7'd20;
        @(posedge clk); #1;
        evt_if.evt_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrt_gate_low", 32'(voice_gate), 32'hE);
        rst_n = 1'b0;
        #1;
        check("midrt_rst_gate",  32'(voice_gate), 32'd0);
        check("midrt_rst_note",  32'(voice_note), 32'd0);
        check("midrt_rst_load",  32'(voice_load), 32'd0);
        check("midrt_rst_ready", 32'(evt_if.evt_ready), 32'd1);
        loads_in_reset = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (voice_load === 1'b1) loads_in_reset++;
            if (c == 3) rst_n = 1'b1;
        end
        check("midrt_no_load",   32'(loads_in_reset), 32'd0);
        check("midrt_ready_out", 32'(evt_if.evt_ready), 32'd1);
        check("midrt_gate_out",  32'(voice_gate), 32'd0);
        send(8'h90, 7'd70, 7'd5, 0, 100);
        check("after_rst_idx",  32'(r_idx), 32'd0);
        check("after_rst_busy", 32'(r_busy), 32'd5);
        check("after_rst_gate", 32'(voice_gate), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Polyphonic voice allocator/scheduler between the MIDI framer and the voice bank.
- Consumes framed MIDI events over a valid/ready handshake and assigns note-ons to voices: same-note reuse first, then the oldest free voice, then the oldest sounding voice (steal).
- Drives per-voice gates and note registers.
- Forces a gate-low retrigger gap whenever a sounding voice is reassigned, so the ADSR sees a fresh gate edge on the sample clock.

Parameters:
- NUM_VOICES, 4: number of voices managed; power of two, ≥2.
- RETRIG_CYCLES, 512: clk cycles gate is held low before re-gating a stolen or retriggered voice; must exceed one sample-clock period.
- AGE_BITS, 8: width of the per-voice saturating age counters.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- evt_valid, in, 1: MIDI event present.
- evt_ready, out, 1: allocator can accept an event.
- evt_cmd, in, 8: MIDI status byte.
- evt_p1, in, 7: note number / CC number.
- evt_p2, in, 7: velocity / CC value.
- voice_gate, out, NUM_VOICES: per-voice gate.
- voice_note, out, 7*NUM_VOICES: per-voice note; voice i occupies bits [7i+6:7i].
- voice_load, out, 1: one-cycle strobe when a voice is assigned.
- voice_load_idx, out, $clog2(NUM_VOICES): index of the assigned voice.
- voice_load_vel, out, 7: velocity of the assigned note.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: voice_gate=0, voice_note=0, voice_load=0, voice_load_idx=0, voice_load_vel=0, all ages = max (saturated), state=IDLE, evt_ready=1.
- Reset asserted mid-operation aborts any scan or retrigger immediately; no voice_load is emitted.
- States: IDLE, SCAN, RETRIG, LOAD.
- evt_ready = (state==IDLE), combinational.
- Accept on evt_valid&&evt_ready; latch cmd/p1/p2. Inputs are ignored while not ready.
- Command decode on evt_cmd[7:4]; channel nibble is ignored (omni).
- 0x9 with p2≠0 (note-on):
  - SCAN visits index 0..NUM_VOICES-1, one per cycle (NUM_VOICES cycles).
  - Selection priority: (a) lowest index with voice_note==p1 and age<max; (b) gate=0 with largest age, ties to lowest index; (c) gate=1 with largest age, ties to lowest index.
  - After SCAN, if the selected voice has gate=1: clear that gate and go to RETRIG. RETRIG counts RETRIG_CYCLES cycles, then goes to LOAD.
  - If the selected voice has gate=0: go directly to LOAD.
  - LOAD (one cycle): set gate, write note, voice_load=1 with idx/vel. Selected voice age←0; all other ages +1, saturating. Return to IDLE.
- Note-on latency: gate rises and voice_load pulses NUM_VOICES+1 clocks after the accept edge, or NUM_VOICES+1+RETRIG_CYCLES when retriggering. On a steal, the gate falls NUM_VOICES+1 clocks after accept. evt_ready returns the cycle after LOAD.
- 0x8, or 0x9 with p2=0 (note-off):
  - SCAN clears the gate of every voice whose note==p1 and gate=1; voice_note is retained so a later same-note note-on reuses the voice.
  - No matching voice: no effect.
  - Back to IDLE after NUM_VOICES cycles; no voice_load.
- 0xB with p1=0x78 or 0x7B (all sound/notes off): all gates cleared at the accept edge; stays IDLE.
- Any other event is accepted and discarded in one cycle.
- Ages only change in LOAD.

Decomposition:
- Package midi_alloc_pkg:
  - Command nibbles: NOTE_ON=4'h9, NOTE_OFF=4'h8, CC=4'hB.
  - CC_ALL_SOUND_OFF=7'h78, CC_ALL_NOTES_OFF=7'h7B.
  - State-encoding localparams.
- One sub-module, midi_voice_picker: sequential best-candidate tracker.
  - Fed one voice per cycle (gate, note, age, index).
  - Holds the running best category/age/index; cleared at scan start.

Test Plan (NUM_VOICES=4, RETRIG_CYCLES=8):
- Reset, then note-on 60 vel 100 -> evt_ready low 5 cycles; voice_load idx0 vel100; voice_gate=4'b0001; voice_note[0]=60; gate rises 5 clocks after accept.
- Note-ons 60,62,64,65, then note-off 62 -> voice_gate=4'b1101; voice_note[1] stays 62; no voice_load during the note-off.
- Five note-ons 60,62,64,65,67 with none released -> voice0 (oldest) gate falls 5 clocks after the 5th accept, stays low 8 cycles, then rises with voice_note[0]=67 and load idx0.
- Note-on 60, note-off 60, note-on 60 -> reuses voice0 without retrigger; same-note note-on while gated -> 8-cycle gate-low gap then re-gate on voice0.
- Note-on with vel 0 on a sounding note -> treated as note-off (gate cleared). CC 0x7B -> all gates 0 one cycle after accept.
- rst_n asserted mid-RETRIG -> outputs return to reset values immediately; no voice_load; evt_ready=1 after release.
